// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared Montgomery
// multiplier core. Accumulator starts at R mod m (Montgomery one). A final
// product with 1 converts the accumulator back to the normal domain.
module mod_exp_ctrl #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned EXP_WIDTH = 512,
  parameter int unsigned LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r_mod_m,
  output logic                 mont_start,
  output logic [WIDTH-1:0]     mont_a,
  output logic [WIDTH-1:0]     mont_b,
  output logic [WIDTH-1:0]     mont_m,
  input  logic [WIDTH-1:0]     mont_result,
  input  logic                 mont_done,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(EXP_WIDTH);

  typedef enum logic [3:0] {
    IDLE, SQ_S, SQ_W, MUL_S, MUL_W, NEXT, FIN_S, FIN_W, DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     acc;
  logic [EXP_WIDTH-1:0] e_q;
  logic [LEN_W-1:0]     idx;

  logic [LEN_W-1:0]     len_c;
  logic [EXP_WIDTH-1:0] e_shift_c;
  logic                 e_bit_c;

  // Exponent length clamp and selection of the current exponent bit e[idx-1]
  always_comb begin
    len_c     = (in_e_len > MAX_LEN) ? MAX_LEN : in_e_len;
    e_shift_c = e_q >> (idx - LEN_W'(1));
    e_bit_c   = e_shift_c[0];
  end

  // Sequencer: operands and start pulse are loaded on entry to each *_S state
  // so they are stable for the whole S/W pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_q        <= '0;
      acc        <= '0;
      e_q        <= '0;
      idx        <= '0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
      mont_m     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q        <= in_x;
            e_q        <= in_e;
            mont_m     <= in_m;
            acc        <= in_r_mod_m;
            idx        <= len_c;
            busy       <= 1'b1;
            mont_start <= 1'b1;
            mont_a     <= in_r_mod_m;
            if (len_c == '0) begin
              mont_b <= WIDTH'(1);
              state  <= FIN_S;
            end else begin
              mont_b <= in_r_mod_m;
              state  <= SQ_S;
            end
          end
        end
        SQ_S: begin
          mont_start <= 1'b0;
          state      <= SQ_W;
        end
        SQ_W: begin
          if (mont_done) begin
            acc <= mont_result;
            if (e_bit_c) begin
              mont_a     <= mont_result;
              mont_b     <= x_q;
              mont_start <= 1'b1;
              state      <= MUL_S;
            end else begin
              state <= NEXT;
            end
          end
        end
        MUL_S: begin
          mont_start <= 1'b0;
          state      <= MUL_W;
        end
        MUL_W: begin
          if (mont_done) begin
            acc   <= mont_result;
            state <= NEXT;
          end
        end
        NEXT: begin
          idx        <= idx - LEN_W'(1);
          mont_start <= 1'b1;
          mont_a     <= acc;
          if (idx == LEN_W'(1)) begin
            mont_b <= WIDTH'(1);
            state  <= FIN_S;
          end else begin
            mont_b <= acc;
            state  <= SQ_S;
          end
        end
        FIN_S: begin
          mont_start <= 1'b0;
          state      <= FIN_W;
        end
        FIN_W: begin
          if (mont_done) begin
            result <= mont_result;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
